uart_echo_buffer: RTL and testbench
===================================

UART_ECHO_BUFFER -- requirements
Module: uart_echo_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: byte width of both streams.
REQ-002 SHALL have parameter DEPTH, default 16: FIFO entries; power of two, >= 2.
REQ-003 SHALL have parameter TERM, default 8'h0D: line-terminator value.
REQ-004 SHALL have port clock  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports rx_data  in  DATA_WIDTH / rx_valid  in  1 / rx_ready  out  1: byte stream from the UART receiver.
REQ-007 SHALL have ports tx_data  out  DATA_WIDTH / tx_valid  out  1 / tx_ready  in  1: byte stream to the UART transmitter.
REQ-008 SHALL have port line_mode  in  1: 0 = per-byte echo, 1 = line-buffered echo.
REQ-009 SHALL have port level  out  $clog2(DEPTH)+1: current FIFO occupancy.
REQ-010 SHALL have port drop_count  out  16: count of bytes lost to overflow, saturating at 16'hFFFF.

Function
REQ-011 SHALL push on rx_valid && rx_ready; pop on tx_valid && tx_ready.
REQ-012 SHALL drive rx_ready = !full.
REQ-013 SHALL discard any byte presented with rx_valid && full, and increment drop_count by 1 (saturating).
REQ-014 SHALL drive tx_data combinationally from the FIFO head entry.
REQ-015 SHALL provide no bypass: a byte pushed into an empty FIFO reaches tx_valid at the earliest one cycle later.
REQ-016 SHALL leave level unchanged on a simultaneous push and pop; SHALL never underflow, since a pop is impossible when empty.
REQ-017 SHALL maintain term_cnt, the number of TERM bytes stored: +1 on push of TERM, -1 on pop of TERM, net 0 when both occur in one cycle.
REQ-018 SHALL implement an FSM with states PASS, HOLD, DRAIN, FORCE.
REQ-019 In PASS, SHALL drive tx_valid = !empty.
REQ-020 In HOLD, SHALL drive tx_valid = 0.
  - Go to DRAIN when term_cnt > 0.
  - Otherwise go to FORCE when full.
REQ-021 In DRAIN, SHALL drive tx_valid = !empty.
  - On popping a TERM byte: return to HOLD if term_cnt (post-update) = 0; otherwise stay in DRAIN.
REQ-022 In FORCE, SHALL drive tx_valid = !empty; return to HOLD when a TERM is popped or the FIFO becomes empty.
  - Purpose: prevents deadlock on a full FIFO with no terminator.
REQ-023 SHALL hold tx_valid and tx_data stable from assertion until the cycle tx_ready is high.
REQ-024 SHALL act on line_mode changes only when !(tx_valid && !tx_ready):
  - PASS -> HOLD on line_mode = 1.
  - HOLD -> PASS on line_mode = 0.
  - DRAIN and FORCE finish their sequence first; line_mode = 0 is then honoured from HOLD.
REQ-025 SHALL wrap read and write pointers modulo DEPTH; full/empty derived from a pointer extra MSB or level.

Reset
REQ-026 SHALL, while reset is high at a clock edge, set:
  - pointers, level, term_cnt, drop_count = 0
  - FSM = PASS
  - tx_valid = 0, rx_ready = 1
REQ-027 SHALL, on reset asserted mid-operation, discard all stored bytes including one being offered on tx; no push or pop occurs in a reset cycle.
REQ-028 SHALL evaluate line_mode in the first cycle after reset (PASS -> HOLD if high).

Structure
REQ-029 SHALL declare the FSM state enum and the default TERM constant in shared package uart_pkg.
REQ-030 SHALL place storage, pointers and level in sub-module sync_fifo (parameters DATA_WIDTH, DEPTH); FSM, term_cnt and drop_count live in uart_echo_buffer.
REQ-031 SHALL let uart_echo_buffer sit between the uart receive and transmit interfaces in the top-level, replacing the direct rx-to-tx wiring.

Verification
REQ-032 Echo: line_mode=0, tx_ready=1; push 0x30, 0x31, 0x32 on consecutive cycles -> tx returns 0x30, 0x31, 0x32 in order, first tx_valid one cycle after first push; level returns to 0.
REQ-033 Line hold: line_mode=1, tx_ready=1; push 'A','B' -> tx_valid stays 0; push 0x0D -> 'A','B',0x0D emitted, then FSM back to HOLD.
REQ-034 Overflow: DEPTH=16, tx_ready=0, line_mode=0; push 20 bytes -> level=16, rx_ready=0, drop_count=4; first 16 bytes later drain intact.
REQ-035 Force: line_mode=1, push 16 non-TERM bytes -> FSM enters FORCE and all 16 bytes are emitted; then HOLD.
REQ-036 Backpressure and reset: tx_ready toggles every cycle -> tx_data stable while tx_valid && !tx_ready; reset mid-stream -> next cycle level=0, tx_valid=0, drop_count=0.
REQ-037 Simultaneous push/pop at level=1 with pushed byte = TERM and popped byte = TERM -> level=1, term_cnt unchanged.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART echo buffer: FSM state encoding and
// the default line-terminator value.
package uart_pkg;

    typedef enum logic [1:0] {
        PASS,
        HOLD,
        DRAIN,
        FORCE
    } echo_state_t;

    localparam logic [7:0] TERM_DEFAULT = 8'h0D;

endpackage

// File: rtl/uart_echo_buffer_sync_fifo.sv
// Synchronous FIFO with occupancy count. The head entry is visible on
// rdata combinationally. Illegal pushes and pops are ignored.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    push,
    input  logic                    pop,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign rdata   = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/uart_echo_buffer.sv
// Echo buffer between UART receiver and transmitter: per-byte echo, or
// line-buffered echo that releases bytes once a terminator is stored.
module uart_echo_buffer
    import uart_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    DEPTH      = 16,
    parameter logic [DATA_WIDTH-1:0] TERM       = DATA_WIDTH'(TERM_DEFAULT)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   rx_data,
    input  logic                    rx_valid,
    output logic                    rx_ready,
    output logic [DATA_WIDTH-1:0]   tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    input  logic                    line_mode,
    output logic [$clog2(DEPTH):0]  level,
    output logic [15:0]             drop_count
);

    localparam int LW = $clog2(DEPTH) + 1;

    echo_state_t   state_q;
    echo_state_t   state_d;
    logic [LW-1:0] term_cnt;
    logic [LW-1:0] term_next;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          push_term;
    logic          pop_term;
    logic          hold_ok;
    logic          last_pop;

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (rx_data),
        .rdata (tx_data),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign rx_ready  = !full;
    assign push      = rx_valid && !full;
    assign pop       = tx_valid && tx_ready;
    assign push_term = push && (rx_data == TERM);
    assign pop_term  = pop && (tx_data == TERM);
    assign hold_ok   = !(tx_valid && !tx_ready);
    assign last_pop  = pop && !push && (level == LW'(1));

    always_comb begin
        term_next = term_cnt;
        if (push_term && !pop_term) begin
            term_next = term_cnt + LW'(1);
        end else if (pop_term && !push_term) begin
            term_next = term_cnt - LW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= PASS;
            term_cnt   <= '0;
            drop_count <= '0;
        end else begin
            state_q  <= state_d;
            term_cnt <= term_next;
            if (rx_valid && full && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

    // Mode changes wait while a byte is offered but not yet taken, so the
    // transmitter never sees tx_valid drop under backpressure.
    always_comb begin
        state_d  = state_q;
        tx_valid = 1'b0;
        case (state_q)
            PASS: begin
                tx_valid = !empty;
                if (hold_ok && line_mode) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                tx_valid = 1'b0;
                if (!line_mode) begin
                    state_d = PASS;
                end else if (term_cnt != '0) begin
                    state_d = DRAIN;
                end else if (full) begin
                    state_d = FORCE;
                end
            end
            DRAIN: begin
                tx_valid = !empty;
                if (pop_term && (term_next == '0)) begin
                    state_d = HOLD;
                end
            end
            FORCE: begin
                tx_valid = !empty;
                if (pop_term || last_pop || empty) begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = PASS;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_echo_buffer.sv
// Directed self-checking bench for uart_echo_buffer with default parameters.
module tb_uart_echo_buffer;
    import uart_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        line_mode = 1'b0;
    logic [4:0]  level;
    logic [15:0] drop_count;

    int checks   = 0;
    int failures = 0;

    uart_echo_buffer dut (
        .clock      (clock),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .line_mode  (line_mode),
        .level      (level),
        .drop_count (drop_count)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [7:0] data);
        rx_valid = valid;
        rx_data  = data;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic resetDut(input logic mode);
        reset     = 1'b1;
        rx_valid  = 1'b0;
        tx_ready  = 1'b0;
        line_mode = mode;
        tick();
        reset = 1'b0;
    endtask

    // Waits (bounded) for tx_valid, checks the offered byte, then lets it pop.
    task automatic expectTx(input string tag, input logic [7:0] expected);
        int waited;
        waited   = 0;
        tx_ready = 1'b1;
        while (!tx_valid && waited < 40) begin
            tick();
            waited++;
        end
        checkOutput({tag, "_valid"}, 32'(tx_valid), 32'd1);
        checkOutput(tag, 32'(tx_data), 32'(expected));
        tick();
    endtask

    initial begin
        $display("[TB] starting uart_echo_buffer bench");

        // Reset state
        resetDut(1'b0);
        checkOutput("rst_level", 32'(level), 32'd0);
        checkOutput("rst_tx_valid", 32'(tx_valid), 32'd0);
        checkOutput("rst_rx_ready", 32'(rx_ready), 32'd1);
        checkOutput("rst_drop", 32'(drop_count), 32'd0);
        checkOutput("rst_state", 32'(dut.state_q), 32'(PASS));

        // Per-byte echo with no bypass
        tx_ready = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h30;
        checkOutput("echo_no_bypass", 32'(tx_valid), 32'd0);
        tick();
        rx_data = 8'h31;
        checkOutput("echo_v0", 32'(tx_valid), 32'd1);
        checkOutput("echo_d0", 32'(tx_data), 32'h30);
        tick();
        rx_data = 8'h32;
        checkOutput("echo_d1", 32'(tx_data), 32'h31);
        tick();
        rx_valid = 1'b0;
        checkOutput("echo_d2", 32'(tx_data), 32'h32);
        tick();
        checkOutput("echo_level", 32'(level), 32'd0);
        checkOutput("echo_idle", 32'(tx_valid), 32'd0);

        // Line hold, line_mode high straight out of reset
        resetDut(1'b1);
        tx_ready = 1'b1;
        applyStimulus(1'b1, 8'h41);
        checkOutput("line_state_hold", 32'(dut.state_q), 32'(HOLD));
        applyStimulus(1'b1, 8'h42);
        checkOutput("line_held", 32'(tx_valid), 32'd0);
        applyStimulus(1'b1, 8'h0D);
        checkOutput("line_held2", 32'(tx_valid), 32'd0);
        checkOutput("line_term_cnt", 32'(dut.term_cnt), 32'd1);
        expectTx("line_A", 8'h41);
        expectTx("line_B", 8'h42);
        expectTx("line_CR", 8'h0D);
        checkOutput("line_back_hold", 32'(dut.state_q), 32'(HOLD));
        checkOutput("line_level", 32'(level), 32'd0);

        // Overflow: 20 pushes into 16 entries with the transmitter stalled
        resetDut(1'b0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 8'(8'h40 + i));
        end
        checkOutput("ovf_level", 32'(level), 32'd16);
        checkOutput("ovf_rx_ready", 32'(rx_ready), 32'd0);
        checkOutput("ovf_drop", 32'(drop_count), 32'd4);
        for (int i = 0; i < 16; i++) begin
            expectTx($sformatf("ovf_byte%0d", i), 8'(8'h40 + i));
        end
        checkOutput("ovf_empty", 32'(level), 32'd0);

        // Force drain of a full FIFO that holds no terminator
        resetDut(1'b1);
        tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 8'(8'h50 + i));
        end
        checkOutput("force_level", 32'(level), 32'd16);
        checkOutput("force_pre_hold", 32'(dut.state_q), 32'(HOLD));
        tick();
        checkOutput("force_state", 32'(dut.state_q), 32'(FORCE));
        for (int i = 0; i < 16; i++) begin
            expectTx($sformatf("force_byte%0d", i), 8'(8'h50 + i));
        end
        checkOutput("force_back_hold", 32'(dut.state_q), 32'(HOLD));
        checkOutput("force_level_end", 32'(level), 32'd0);

        // Backpressure: tx_ready toggles, offered byte must stay put
        resetDut(1'b0);
        applyStimulus(1'b1, 8'h61);
        applyStimulus(1'b1, 8'h62);
        applyStimulus(1'b1, 8'h63);
        begin
            logic [7:0] exp_data [4];
            exp_data = '{8'h61, 8'h61, 8'h62, 8'h62};
            for (int i = 0; i < 4; i++) begin
                tx_ready = i[0];
                checkOutput($sformatf("bp_valid%0d", i), 32'(tx_valid), 32'd1);
                checkOutput($sformatf("bp_data%0d", i), 32'(tx_data), 32'(exp_data[i]));
                tick();
            end
        end
        tx_ready = 1'b0;
        checkOutput("bp_level", 32'(level), 32'd1);
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b1, 8'(8'h70 + i));
        end
        checkOutput("bp_full", 32'(level), 32'd16);
        checkOutput("bp_drop", 32'(drop_count), 32'd2);

        // Reset mid-stream while a byte is offered and another is pushed
        reset    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h99;
        tx_ready = 1'b1;
        tick();
        reset    = 1'b0;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        checkOutput("mid_rst_level", 32'(level), 32'd0);
        checkOutput("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
        checkOutput("mid_rst_drop", 32'(drop_count), 32'd0);
        checkOutput("mid_rst_state", 32'(dut.state_q), 32'(PASS));

        // Simultaneous push and pop of TERM at level 1
        applyStimulus(1'b1, 8'h0D);
        checkOutput("sim_term_cnt0", 32'(dut.term_cnt), 32'd1);
        checkOutput("sim_level0", 32'(level), 32'd1);
        tx_ready = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h0D;
        checkOutput("sim_head", 32'(tx_data), 32'h0D);
        tick();
        rx_valid = 1'b0;
        checkOutput("sim_level1", 32'(level), 32'd1);
        checkOutput("sim_term_cnt1", 32'(dut.term_cnt), 32'd1);
        tick();
        checkOutput("sim_level2", 32'(level), 32'd0);
        checkOutput("sim_term_cnt2", 32'(dut.term_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
